rx_fifo: RTL and testbench
==========================

RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, 4 to 256.
REQ-002 Parameter ADDR_W, default 4, equals log2(DEPTH).
REQ-003 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_en  input  1  FIFO enable; low holds FIFO empty.
REQ-006 rx_success  input  1  one-cycle write strobe from receiver.
REQ-007 rx_data  input  9  received character, LSB-aligned.
REQ-008 rx_error  input  3  receiver error: [2] frame, [1] parity, [0] overrun (ignored).
REQ-009 rd_en  input  1  pop head entry.
REQ-010 flush  input  1  synchronous clear of contents.
REQ-011 ovr_clr  input  1  clears sticky overrun flag.
REQ-012 trig_level  input  2  interrupt threshold select.
REQ-013 timeout_cycles  input  16  idle timeout in clk cycles; 0 disables timeout.
REQ-014 rd_data  output  9  head entry data.
REQ-015 rd_err  output  2  head entry errors: [1] frame, [0] parity.
REQ-016 fifo_full  output  1  count == DEPTH; fed back to receiver.
REQ-017 fifo_empty  output  1  count == 0.
REQ-018 count  output  ADDR_W+1  stored entries.
REQ-019 overrun  output  1  sticky: character lost.
REQ-020 trig_irq  output  1  level: count at or above threshold.
REQ-021 timeout_irq  output  1  level: stale data pending.

Function
REQ-022 Storage: DEPTH entries of 11 bits {rx_error[2:1], rx_data}; circular rd_ptr/wr_ptr of ADDR_W bits, wrapping DEPTH-1 -> 0.
REQ-023 Write accepted on rx_success & fifo_en & ~flush & (~fifo_full | pop), pop = rd_en & ~fifo_empty.
REQ-024 Pop on rd_en & ~fifo_empty; rd_en while empty ignored, no pointer or count change.
REQ-025 Show-ahead: rd_data/rd_err present head entry combinationally from rd_ptr; both 0 while empty.
REQ-026 Written entry appears on rd_data the cycle after its write edge if FIFO was empty.
REQ-027 Simultaneous write and pop: count unchanged, both pointers advance; allowed at full and at empty+write (pop suppressed at empty).
REQ-028 count, fifo_full, fifo_empty update on the same edge as the accepted write/pop.
REQ-029 overrun set on rx_success & fifo_en while fifo_full & ~pop; data dropped; cleared only by ovr_clr, reset; set wins over simultaneous ovr_clr.
REQ-030 flush or fifo_en low: pointers and count to 0 next edge, overrun unaffected, incoming write discarded.
REQ-031 Threshold: trig_level 00->1, 01->4, 10->8, 11->DEPTH-2; trig_irq registered, = (count >= threshold), updated one cycle after count.
REQ-032 Timeout counter (16-bit): cleared on accepted write, pop, flush, or count==0; else increments, saturating at timeout_cycles.
REQ-033 timeout_irq set when counter == timeout_cycles and timeout_cycles != 0 and count != 0; cleared with counter clear.

Reset
REQ-034 rst_n low: pointers, count, overrun, trig_irq, timeout_irq, timeout counter = 0; fifo_empty = 1; fifo_full = 0; rd_data/rd_err = 0.
REQ-035 Memory contents are not reset; unreadable until written.
REQ-036 Reset mid-operation discards all entries immediately, asynchronously.

Configuration
REQ-037 Macro RX_FIFO_TIMEOUT_EN defined: timeout counter and timeout_irq behave per REQ-032/033.
REQ-038 RX_FIFO_TIMEOUT_EN undefined: no timeout counter; timeout_irq tied 0; timeout_cycles port present, unused.

Verification
REQ-039 Write 0x1A5,0x003,0x0FF with rx_error=0 -> rd_data 0x1A5 one cycle after first write, count=3; three pops return in order, fifo_empty=1.
REQ-040 Write 16 entries, then 17th rx_success without rd_en -> fifo_full=1, overrun=1, count=16, 17th data absent; ovr_clr -> overrun=0.
REQ-041 At full, rx_success with rd_en same cycle -> count stays 16, overrun=0, new entry read last.
REQ-042 trig_level=01, write 4 entries -> trig_irq rises one cycle after count=4; pop one -> falls one cycle after count=3.
REQ-043 Macro defined, timeout_cycles=100, write 1 entry then idle -> timeout_irq=1 at 100th idle cycle; pop -> 0 next cycle; macro undefined -> never 1.
REQ-044 Write entry with rx_error=3'b110, then flush -> rd_err showed 2'b11 before flush; after flush count=0, rd_data=0.

Source files
------------

// File: rtl/rx_fifo.sv
// rx_fifo: receive character FIFO with show-ahead read port, sticky overrun,
// threshold interrupt and optional idle-timeout interrupt.
// Optional feature macro: RX_FIFO_TIMEOUT_EN enables the idle-timeout counter
// and timeout_irq; without it timeout_irq is tied low and timeout_cycles is unused.
module rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_en,
  input  logic              rx_success,
  input  logic [8:0]        rx_data,
  input  logic [2:0]        rx_error,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              ovr_clr,
  input  logic [1:0]        trig_level,
  input  logic [15:0]       timeout_cycles,
  output logic [8:0]        rd_data,
  output logic [1:0]        rd_err,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              trig_irq,
  output logic              timeout_irq
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  // Storage is deliberately not reset; an entry is only visible once written.
  logic [10:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              trig_irq_q, trig_irq_d;
  logic [8:0]        thr_s;
  logic [10:0]       head_s;
  logic              empty_s, full_s, pop_s, wr_s, clear_s;
  logic              unused_s;

  assign empty_s = (count_q == {(ADDR_W + 1){1'b0}});
  assign full_s  = (count_q == DEPTH_C);
  assign pop_s   = rd_en & ~empty_s;
  assign clear_s = flush | ~fifo_en;
  // Full is relieved by a same-cycle pop, so write-at-full with pop is legal.
  assign wr_s    = rx_success & fifo_en & ~flush & (~full_s | pop_s);
  assign head_s  = mem_q[rd_ptr_q];

`ifdef RX_FIFO_TIMEOUT_EN
  assign unused_s = rx_error[0];
`else
  assign unused_s = ^{rx_error[0], timeout_cycles};
`endif

  // Next-state for pointers, occupancy, sticky overrun and threshold interrupt.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    thr_s      = 9'd1;
    if (clear_s) begin
      rd_ptr_d = {ADDR_W{1'b0}};
      wr_ptr_d = {ADDR_W{1'b0}};
      count_d  = {(ADDR_W + 1){1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // A lost character wins over a clear request in the same cycle.
    if (rx_success & fifo_en & full_s & ~pop_s) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    case (trig_level)
      2'b00:   thr_s = 9'd1;
      2'b01:   thr_s = 9'd4;
      2'b10:   thr_s = 9'd8;
      2'b11:   thr_s = 9'(DEPTH - 2);
      default: thr_s = 9'd1;
    endcase
    // Compared against the current count, so the interrupt lags count by one cycle.
    trig_irq_d = (9'(count_q) >= thr_s);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= {ADDR_W{1'b0}};
      wr_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= {(ADDR_W + 1){1'b0}};
      overrun_q  <= 1'b0;
      trig_irq_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      trig_irq_q <= trig_irq_d;
    end
  end

  // Entry storage write: {frame, parity, data}.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= {rx_error[2:1], rx_data};
    end
  end

  // Show-ahead read port, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      rd_data = 9'd0;
      rd_err  = 2'd0;
    end else begin
      rd_data = head_s[8:0];
      rd_err  = head_s[10:9];
    end
  end

`ifdef RX_FIFO_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_irq_q, timeout_irq_d;
  logic        to_clr_s;

  assign to_clr_s = wr_s | pop_s | clear_s | empty_s;

  // Idle counter saturating at the programmed timeout; any activity restarts it.
  always_comb begin
    to_cnt_d      = to_cnt_q;
    timeout_irq_d = 1'b0;
    if (to_clr_s) begin
      to_cnt_d = 16'd0;
    end else if (to_cnt_q < timeout_cycles) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end else begin
      to_cnt_d = timeout_cycles;
    end
    timeout_irq_d = ~to_clr_s & (timeout_cycles != 16'd0) & (to_cnt_d == timeout_cycles);
  end

  // Timeout counter and interrupt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= 16'd0;
      timeout_irq_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_irq_q <= timeout_irq_d;
    end
  end

  assign timeout_irq = timeout_irq_q;
`else
  assign timeout_irq = 1'b0;
`endif

  assign fifo_full  = full_s;
  assign fifo_empty = empty_s;
  assign count      = count_q;
  assign overrun    = overrun_q;
  assign trig_irq   = trig_irq_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rx_fifo;

  localparam int DEPTH = 16;
`ifdef RX_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_en = 1'b1;
  logic        rx_success = 1'b0;
  logic [8:0]  rx_data = 9'd0;
  logic [2:0]  rx_error = 3'd0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [1:0]  trig_level = 2'd0;
  logic [15:0] timeout_cycles = 16'd0;
  logic [8:0]  rd_data;
  logic [1:0]  rd_err;
  logic        fifo_full, fifo_empty;
  logic [4:0]  count;
  logic        overrun, trig_irq, timeout_irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [10:0] mq[$];
  bit        m_ovr, m_trig, m_tirq;
  int        m_idle;

  rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_en(fifo_en), .rx_success(rx_success),
    .rx_data(rx_data), .rx_error(rx_error), .rd_en(rd_en), .flush(flush),
    .ovr_clr(ovr_clr), .trig_level(trig_level), .timeout_cycles(timeout_cycles),
    .rd_data(rd_data), .rd_err(rd_err), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .count(count), .overrun(overrun),
    .trig_irq(trig_irq), .timeout_irq(timeout_irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit [10:0] h;
    h = (mq.size() != 0) ? mq[0] : 11'd0;
    chk("rd_data", int'(rd_data), int'(h[8:0]));
    chk("rd_err", int'(rd_err), int'(h[10:9]));
    chk("count", int'(count), mq.size());
    chk("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
    chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("trig_irq", int'(trig_irq), int'(m_trig));
    chk("timeout_irq", int'(timeout_irq), int'(m_tirq));
  endtask

  // Advance one clock: predict from the inputs now applied, then check.
  task automatic step();
    int  sz, thr, tc;
    bit  full, pop, clr, wr;
    sz   = mq.size();
    tc   = int'(timeout_cycles);
    full = (sz == DEPTH);
    pop  = rd_en && (sz > 0);
    clr  = !fifo_en || flush;
    wr   = rx_success && fifo_en && !flush && (!full || pop);
    case (trig_level)
      2'd0:    thr = 1;
      2'd1:    thr = 4;
      2'd2:    thr = 8;
      default: thr = DEPTH - 2;
    endcase
    m_trig = (sz >= thr);
    if (rx_success && fifo_en && full && !pop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (clr) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (wr) mq.push_back({rx_error[2:1], rx_data});
    end
    if (wr || pop || clr || sz == 0) m_idle = 0;
    else m_idle = (m_idle + 1 > tc) ? tc : m_idle + 1;
    m_tirq = TO_EN && (tc != 0) && (m_idle == tc) && (mq.size() != 0);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    rx_success = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0; fifo_en = 1'b1;
  endtask

  task automatic wr1(input logic [8:0] d, input logic [2:0] e);
    rx_success = 1'b1; rx_data = d; rx_error = e;
    step();
    rx_success = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  // Asynchronous reset away from any rising edge; checks take effect immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    mq.delete(); m_ovr = 1'b0; m_trig = 1'b0; m_tirq = 1'b0; m_idle = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_err", int'(rd_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_trig", int'(trig_irq), 0);
    chk("rst_tirq", int'(timeout_irq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Three writes then in-order reads
    wr1(9'h1A5, 3'd0);
    chk("t1_first_head", int'(rd_data), 'h1A5);
    wr1(9'h003, 3'd0);
    wr1(9'h0FF, 3'd0);
    chk("t1_count3", int'(count), 3);
    chk("t1_pop0", int'(rd_data), 'h1A5); pop1();
    chk("t1_pop1", int'(rd_data), 'h003); pop1();
    chk("t1_pop2", int'(rd_data), 'h0FF); pop1();
    chk("t1_empty", int'(fifo_empty), 1);

    // Fill, then overflow without a pop
    for (int i = 0; i < DEPTH; i++) wr1(9'(i), 3'd0);
    wr1(9'h1FF, 3'd0);
    chk("t2_full", int'(fifo_full), 1);
    chk("t2_overrun", int'(overrun), 1);
    chk("t2_count", int'(count), 16);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("t2_ovr_clr", int'(overrun), 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_order", int'(rd_data), i);
      pop1();
    end

    // Write with pop at full
    for (int i = 0; i < DEPTH; i++) wr1(9'(9'h100 + i), 3'd0);
    rx_success = 1'b1; rx_data = 9'h155; rx_error = 3'd0; rd_en = 1'b1;
    step();
    idle_inputs();
    chk("t3_count", int'(count), 16);
    chk("t3_overrun", int'(overrun), 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_order", int'(rd_data), (i < 15) ? ('h101 + i) : 'h155);
      pop1();
    end

    // Threshold interrupt at level 4
    trig_level = 2'b01;
    for (int i = 0; i < 4; i++) wr1(9'(9'h040 + i), 3'd0);
    chk("t4_count4", int'(count), 4);
    chk("t4_trig_lag", int'(trig_irq), 0);
    step();
    chk("t4_trig_rise", int'(trig_irq), 1);
    pop1();
    chk("t4_count3", int'(count), 3);
    chk("t4_trig_hold", int'(trig_irq), 1);
    step();
    chk("t4_trig_fall", int'(trig_irq), 0);
    for (int i = 0; i < 3; i++) pop1();

    // Idle timeout
    timeout_cycles = 16'd100;
    wr1(9'h077, 3'd0);
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 99) chk("t5_tirq_early", int'(timeout_irq), 0);
      if (k == 100) chk("t5_tirq_set", int'(timeout_irq), int'(TO_EN));
    end
    pop1();
    chk("t5_tirq_pop", int'(timeout_irq), 0);
    timeout_cycles = 16'd0;

    // Error bits then flush
    wr1(9'h0AA, 3'b110);
    chk("t6_rd_err", int'(rd_err), 3);
    chk("t6_rd_data", int'(rd_data), 'h0AA);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t6_flush_count", int'(count), 0);
    chk("t6_flush_data", int'(rd_data), 0);

    // Reset mid-operation
    wr1(9'h011, 3'd0); wr1(9'h022, 3'd0); wr1(9'h033, 3'd0);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int pw, pr;
      case ((c / 150) % 3)
        0:       begin pw = 85; pr = 20; end
        1:       begin pw = 20; pr = 85; end
        default: begin pw = 50; pr = 50; end
      endcase
      if (c % 256 == 0) timeout_cycles = 16'($urandom_range(0, 12));
      rx_success = ($urandom_range(0, 99) < pw);
      rd_en      = ($urandom_range(0, 99) < pr);
      rx_data    = 9'($urandom);
      rx_error   = 3'($urandom);
      flush      = ($urandom_range(0, 99) < 1);
      fifo_en    = !($urandom_range(0, 199) < 1);
      ovr_clr    = ($urandom_range(0, 99) < 5);
      trig_level = 2'($urandom);
      step();
      if (c == 1500) begin
        idle_inputs();
        do_reset();
      end
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
